// File: rtl/lsu_pkg.sv
// Shared types and default widths for the load/store unit.
package lsu_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int RW_DEF = 3;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    RESP
  } state_t;

  typedef enum logic {
    OP_LD,
    OP_ST
  } op_t;

endpackage

// File: rtl/lsu_sat_counter.sv
// Saturating up-counter used for the load/store diagnostics.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          inc,
  output logic [CW-1:0] count
);

  // Count completed accesses, sticking at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage sequencer: one load or store in flight, strobes only on odd-PC cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [12:0]   PC,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_load,
  input  logic          req_store,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [RW-1:0] req_rd,
  output logic [AW-1:0] DataAddress,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic [DW-1:0] DataIn,
  input  logic [DW-1:0] DataOut,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          st_done,
  output logic          err,
  output logic [CW-1:0] load_cnt,
  output logic [CW-1:0] store_cnt
);

  state_t        state;
  state_t        state_next;
  op_t           op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [RW-1:0] rd_q;
  logic          accept;
  logic          illegal;
  logic          ld_commit;
  logic          st_commit;
  logic          unused_pc_bits;

  // Only the access phase bit of the PC matters here.
  assign unused_pc_bits = ^PC[12:1];

  assign DataAddress = addr_q;
  assign DataIn      = wdata_q;

  // State register; reset aborts any pending access immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, handshake and memory strobe decode.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    ReadMem    = 1'b0;
    WriteMem   = 1'b0;
    wb_valid   = 1'b0;
    accept     = 1'b0;
    illegal    = 1'b0;
    ld_commit  = 1'b0;
    st_commit  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_load ^ req_store) begin
            accept     = 1'b1;
            state_next = PEND;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      PEND: begin
        if (PC[0]) begin
          if (op_q == OP_LD) begin
            ReadMem    = 1'b1;
            ld_commit  = 1'b1;
            state_next = RESP;
          end else begin
            WriteMem   = 1'b1;
            st_commit  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      RESP: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latches, load result capture and one-cycle status pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q    <= OP_LD;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
      st_done <= 1'b0;
      err     <= 1'b0;
    end else begin
      st_done <= st_commit;
      err     <= illegal;
      if (accept) begin
        op_q    <= req_store ? OP_ST : OP_LD;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
      end
      if (ld_commit) begin
        wb_data <= DataOut;
        wb_rd   <= rd_q;
      end
    end
  end

  sat_counter #(.CW(CW)) u_load_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (ld_commit),
    .count (load_cnt)
  );

  sat_counter #(.CW(CW)) u_store_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (st_commit),
    .count (store_cnt)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural data memory.
module tb_load_store_unit;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RW = 3;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic [12:0]   pc;
  logic          req_valid;
  logic          req_ready;
  logic          req_load;
  logic          req_store;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [RW-1:0] req_rd;
  logic [AW-1:0] data_address;
  logic          read_mem;
  logic          write_mem;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          wb_valid;
  logic          wb_ready;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          st_done;
  logic          err;
  logic [CW-1:0] load_cnt;
  logic [CW-1:0] store_cnt;

  logic [DW-1:0] mem [0:255];

  int tests;
  int fails;

  load_store_unit #(.AW(AW), .DW(DW), .RW(RW), .CW(CW)) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .PC          (pc),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_load    (req_load),
    .req_store   (req_store),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rd      (req_rd),
    .DataAddress (data_address),
    .ReadMem     (read_mem),
    .WriteMem    (write_mem),
    .DataIn      (data_in),
    .DataOut     (data_out),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .st_done     (st_done),
    .err         (err),
    .load_cnt    (load_cnt),
    .store_cnt   (store_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory with combinational read and write on the rising edge.
  assign data_out = mem[data_address];

  always @(posedge clk) begin
    if (write_mem === 1'b1) mem[data_address] <= data_in;
  end

  // Apply one cycle of inputs at the falling edge and settle before checks.
  task automatic drive(input logic [12:0] p, input logic v, input logic ld, input logic st,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [RW-1:0] r,
                       input logic wr);
    @(negedge clk);
    pc        = p;
    req_valid = v;
    req_load  = ld;
    req_store = st;
    req_addr  = a;
    req_wdata = d;
    req_rd    = r;
    wb_ready  = wr;
    #1;
  endtask

  task automatic idle_cycle(input logic [12:0] p);
    drive(p, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_cycle(13'd0);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
    tests++; if (read_mem !== 1'b0) begin fails++; $display("[TB] FAIL reset_read_mem got %b want 0", read_mem); end
    tests++; if (write_mem !== 1'b0) begin fails++; $display("[TB] FAIL reset_write_mem got %b want 0", write_mem); end
    tests++; if (data_address !== 8'h00) begin fails++; $display("[TB] FAIL reset_data_address got %h want 00", data_address); end
    tests++; if (data_in !== 8'h00) begin fails++; $display("[TB] FAIL reset_data_in got %h want 00", data_in); end
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_wb_valid got %b want 0", wb_valid); end
    tests++; if (wb_rd !== 3'd0) begin fails++; $display("[TB] FAIL reset_wb_rd got %0d want 0", wb_rd); end
    tests++; if (wb_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_wb_data got %h want 00", wb_data); end
    tests++; if (st_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_st_done got %b want 0", st_done); end
    tests++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err got %b want 0", err); end
    tests++; if (load_cnt !== 8'h00) begin fails++; $display("[TB] FAIL reset_load_cnt got %h want 00", load_cnt); end
    tests++; if (store_cnt !== 8'h00) begin fails++; $display("[TB] FAIL reset_store_cnt got %h want 00", store_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle_cycle(13'(i));
      tests++; if (read_mem !== 1'b0 || write_mem !== 1'b0) begin fails++; $display("[TB] FAIL idle_strobe cycle %0d got rd=%b wr=%b want 0/0", i, read_mem, write_mem); end
    end
  endtask

  task automatic test_store_load;
    drive(13'd4, 1'b1, 1'b0, 1'b1, 8'h2A, 8'h5C, 3'd0, 1'b0);
    tests++; if (req_ready !== 1'b1 || write_mem !== 1'b0) begin fails++; $display("[TB] FAIL st_accept got ready=%b wr=%b want 1/0", req_ready, write_mem); end
    idle_cycle(13'd5);
    tests++; if (write_mem !== 1'b1 || read_mem !== 1'b0) begin fails++; $display("[TB] FAIL st_strobe got wr=%b rd=%b want 1/0", write_mem, read_mem); end
    tests++; if (data_address !== 8'h2A || data_in !== 8'h5C) begin fails++; $display("[TB] FAIL st_bus got addr=%h data=%h want 2a/5c", data_address, data_in); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL st_pend_ready got %b want 0", req_ready); end
    drive(13'd6, 1'b1, 1'b1, 1'b0, 8'h2A, 8'h00, 3'd3, 1'b1);
    tests++; if (st_done !== 1'b1 || write_mem !== 1'b0) begin fails++; $display("[TB] FAIL st_done got done=%b wr=%b want 1/0", st_done, write_mem); end
    tests++; if (store_cnt !== 8'd1) begin fails++; $display("[TB] FAIL st_count got %0d want 1", store_cnt); end
    tests++; if (mem[8'h2A] !== 8'h5C) begin fails++; $display("[TB] FAIL st_mem got %h want 5c", mem[8'h2A]); end
    idle_cycle(13'd7);
    wb_ready = 1'b1;
    tests++; if (read_mem !== 1'b1 || write_mem !== 1'b0 || st_done !== 1'b0) begin fails++; $display("[TB] FAIL ld_strobe got rd=%b wr=%b done=%b want 1/0/0", read_mem, write_mem, st_done); end
    drive(13'd8, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tests++; if (wb_valid !== 1'b1 || wb_rd !== 3'd3 || wb_data !== 8'h5C) begin fails++; $display("[TB] FAIL ld_result got v=%b rd=%0d data=%h want 1/3/5c", wb_valid, wb_rd, wb_data); end
    tests++; if (load_cnt !== 8'd1 || req_ready !== 1'b0) begin fails++; $display("[TB] FAIL ld_count got cnt=%0d ready=%b want 1/0", load_cnt, req_ready); end
    idle_cycle(13'd9);
    tests++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("[TB] FAIL ld_done got v=%b ready=%b want 0/1", wb_valid, req_ready); end
  endtask

  task automatic test_phase_align;
    drive(13'd9, 1'b1, 1'b1, 1'b0, 8'h2A, 8'h00, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(13'd10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      tests++; if (read_mem !== 1'b0 || write_mem !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("[TB] FAIL phase_hold %0d got rd=%b wr=%b ready=%b want 0/0/0", i, read_mem, write_mem, req_ready); end
    end
    drive(13'd11, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tests++; if (read_mem !== 1'b1) begin fails++; $display("[TB] FAIL phase_strobe got %b want 1", read_mem); end
    drive(13'd12, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tests++; if (wb_valid !== 1'b1 || wb_rd !== 3'd5 || wb_data !== 8'h5C || load_cnt !== 8'd2) begin fails++; $display("[TB] FAIL phase_result got v=%b rd=%0d data=%h cnt=%0d want 1/5/5c/2", wb_valid, wb_rd, wb_data, load_cnt); end
    idle_cycle(13'd13);
    tests++; if (req_ready !== 1'b1 || read_mem !== 1'b0) begin fails++; $display("[TB] FAIL phase_idle got ready=%b rd=%b want 1/0", req_ready, read_mem); end
  endtask

  task automatic test_backpressure;
    drive(13'd0, 1'b1, 1'b1, 1'b0, 8'h33, 8'h00, 3'd6, 1'b0);
    idle_cycle(13'd1);
    tests++; if (read_mem !== 1'b1 || data_address !== 8'h33) begin fails++; $display("[TB] FAIL bp_strobe got rd=%b addr=%h want 1/33", read_mem, data_address); end
    for (int i = 0; i < 4; i++) begin
      idle_cycle(13'(i + 2));
      tests++; if (wb_valid !== 1'b1 || wb_data !== 8'hC4 || wb_rd !== 3'd6 || req_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_hold %0d got v=%b data=%h rd=%0d ready=%b want 1/c4/6/0", i, wb_valid, wb_data, wb_rd, req_ready); end
    end
    drive(13'd6, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tests++; if (wb_valid !== 1'b1 || load_cnt !== 8'd3) begin fails++; $display("[TB] FAIL bp_release got v=%b cnt=%0d want 1/3", wb_valid, load_cnt); end
    idle_cycle(13'd7);
    tests++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_idle got v=%b ready=%b want 0/1", wb_valid, req_ready); end
  endtask

  task automatic test_illegal;
    drive(13'd1, 1'b1, 1'b1, 1'b1, 8'h2A, 8'h11, 3'd2, 1'b0);
    tests++; if (err !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("[TB] FAIL ill_pre got err=%b ready=%b want 0/1", err, req_ready); end
    idle_cycle(13'd1);
    tests++; if (err !== 1'b1 || read_mem !== 1'b0 || write_mem !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("[TB] FAIL ill_both got err=%b rd=%b wr=%b ready=%b want 1/0/0/1", err, read_mem, write_mem, req_ready); end
    drive(13'd1, 1'b1, 1'b0, 1'b0, 8'h2A, 8'h11, 3'd2, 1'b0);
    tests++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL ill_once got %b want 0", err); end
    idle_cycle(13'd1);
    tests++; if (err !== 1'b1 || read_mem !== 1'b0 || write_mem !== 1'b0) begin fails++; $display("[TB] FAIL ill_neither got err=%b rd=%b wr=%b want 1/0/0", err, read_mem, write_mem); end
    idle_cycle(13'd1);
    tests++; if (err !== 1'b0 || load_cnt !== 8'd3 || store_cnt !== 8'd1) begin fails++; $display("[TB] FAIL ill_counts got err=%b ld=%0d st=%0d want 0/3/1", err, load_cnt, store_cnt); end
  endtask

  task automatic test_reset_mid;
    drive(13'd0, 1'b1, 1'b0, 1'b1, 8'h44, 8'h99, 3'd0, 1'b0);
    idle_cycle(13'd0);
    tests++; if (write_mem !== 1'b0 || data_address !== 8'h44) begin fails++; $display("[TB] FAIL rm_pend got wr=%b addr=%h want 0/44", write_mem, data_address); end
    idle_cycle(13'd1);
    tests++; if (write_mem !== 1'b1) begin fails++; $display("[TB] FAIL rm_armed got %b want 1", write_mem); end
    rst_n = 1'b0;
    #1;
    tests++; if (write_mem !== 1'b0 || read_mem !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("[TB] FAIL rm_abort got wr=%b rd=%b ready=%b want 0/0/1", write_mem, read_mem, req_ready); end
    tests++; if (data_address !== 8'h00 || data_in !== 8'h00 || wb_data !== 8'h00 || wb_rd !== 3'd0) begin fails++; $display("[TB] FAIL rm_regs got addr=%h din=%h wbd=%h wbrd=%0d want 0", data_address, data_in, wb_data, wb_rd); end
    tests++; if (load_cnt !== 8'd0 || store_cnt !== 8'd0 || wb_valid !== 1'b0 || st_done !== 1'b0 || err !== 1'b0) begin fails++; $display("[TB] FAIL rm_status got ld=%0d st=%0d v=%b done=%b err=%b want 0", load_cnt, store_cnt, wb_valid, st_done, err); end
    for (int i = 0; i < 4; i++) begin
      idle_cycle(13'(i + 1));
      tests++; if (write_mem !== 1'b0 || read_mem !== 1'b0) begin fails++; $display("[TB] FAIL rm_quiet %0d got wr=%b rd=%b want 0/0", i, write_mem, read_mem); end
    end
    tests++; if (mem[8'h44] !== 8'h00) begin fails++; $display("[TB] FAIL rm_mem got %h want 00", mem[8'h44]); end
    rst_n = 1'b1;
    idle_cycle(13'd1);
    tests++; if (st_done !== 1'b0 || req_ready !== 1'b1 || write_mem !== 1'b0) begin fails++; $display("[TB] FAIL rm_after got done=%b ready=%b wr=%b want 0/1/0", st_done, req_ready, write_mem); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      drive(13'd1, 1'b1, 1'b0, 1'b1, 8'(i), 8'(i), 3'd0, 1'b0);
      idle_cycle(13'd1);
      if (i == 253) begin
        idle_cycle(13'd1);
        tests++; if (store_cnt !== 8'hFE) begin fails++; $display("[TB] FAIL sat_before got %h want fe", store_cnt); end
      end
      if (i == 254) begin
        idle_cycle(13'd1);
        tests++; if (store_cnt !== 8'hFF) begin fails++; $display("[TB] FAIL sat_reach got %h want ff", store_cnt); end
      end
    end
    idle_cycle(13'd1);
    tests++; if (store_cnt !== 8'hFF || load_cnt !== 8'h00) begin fails++; $display("[TB] FAIL sat_final got st=%h ld=%h want ff/00", store_cnt, load_cnt); end
  endtask

  // Test sequence.
  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    pc        = '0;
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_store = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_rd    = '0;
    wb_ready  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h33] = 8'hC4;
    test_reset;
    test_store_load;
    test_phase_align;
    test_backpressure;
    test_illegal;
    test_reset_mid;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
